// File: rtl/mmio_subsys.sv
// mmio_subsys: small memory-mapped subsystem with a word RAM, a GPIO output
// register (write, set, clear and toggle views) and a 32-bit timer with a
// compare match, an auto-reload option and a level interrupt.
//
// Ports
//   clock        rising-edge clock
//   rst          asynchronous active-low reset
//   memread      read strobe, at most one request per cycle
//   memwrite_cs  write strobe
//   i_addr       byte address; bits [1:0] are ignored
//   i_wdata      write data
//   o_rdata      read data, qualified by o_rvalid, held otherwise
//   o_rvalid     one-cycle pulse, the cycle after memread was sampled
//   o_gpio       GPIO output register
//   o_irq        timer interrupt (match AND irq-enable)
//
// Bus handshake: there is no back-pressure. A read is accepted on every edge
// where memread=1; exactly one cycle later o_rvalid=1 for one cycle with the
// data. A write takes effect on the edge where memwrite_cs=1. When both
// strobes hit the same address on the same edge, the read returns the value
// held before that write.
//
// Register map (byte addresses):
//   0x000..  RAM (RAM_WORDS words)
//   0x400 GPIO_OUT R/W   0x404 GPIO_SET W   0x408 GPIO_CLR W   0x40C GPIO_TGL W
//   0x410 TMR_CNT  R/W   0x414 TMR_CMP R/W
//   0x418 TMR_CTRL R/W (bit0 enable, bit1 auto-reload, bit2 irq enable)
//   0x41C TMR_STAT R, W1C (bit0 match)
module mmio_subsys #(
  parameter int RAM_WORDS = 16,
  parameter int GPIO_W    = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              memread,
  input  logic              memwrite_cs,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic              o_rvalid,
  output logic [GPIO_W-1:0] o_gpio,
  output logic              o_irq
);

  localparam int AW = $clog2(RAM_WORDS);

  localparam logic [2:0] SEL_GPIO_OUT = 3'd0;
  localparam logic [2:0] SEL_GPIO_SET = 3'd1;
  localparam logic [2:0] SEL_GPIO_CLR = 3'd2;
  localparam logic [2:0] SEL_GPIO_TGL = 3'd3;
  localparam logic [2:0] SEL_TMR_CNT  = 3'd4;
  localparam logic [2:0] SEL_TMR_CMP  = 3'd5;
  localparam logic [2:0] SEL_TMR_CTRL = 3'd6;
  localparam logic [2:0] SEL_TMR_STAT = 3'd7;

  logic [31:0] r_ram [RAM_WORDS];
  logic [31:0] r_cnt;
  logic [31:0] r_cmp;
  logic [2:0]  r_ctrl;
  logic        r_match;

  logic [29:0]   w_word;
  logic          w_reg_hit;
  logic [2:0]    w_sel;
  logic          w_ram_hit;
  logic [AW-1:0] w_ram_idx;
  logic [31:0]   w_rdata;
  logic          w_wr_reg;
  logic          w_match_now;
  logic          w_unused;

  // Address decode. The eight registers occupy words 0x100..0x107; they take
  // precedence over RAM in case a large RAM_WORDS would overlap them.
  assign w_word    = i_addr[31:2];
  assign w_reg_hit = (w_word[29:3] == 27'h20);
  assign w_sel     = w_word[2:0];
  assign w_ram_hit = (i_addr[31:AW+2] == '0) && !w_reg_hit;
  assign w_ram_idx = i_addr[AW+1:2];
  assign w_wr_reg  = memwrite_cs && w_reg_hit;
  assign w_unused  = &{1'b0, i_addr[1:0]};

  // Read mux from current (pre-write) state; write-only and unmapped read 0.
  always_comb begin
    w_rdata = '0;
    if (w_reg_hit) begin
      case (w_sel)
        SEL_GPIO_OUT: w_rdata[GPIO_W-1:0] = o_gpio;
        SEL_TMR_CNT:  w_rdata = r_cnt;
        SEL_TMR_CMP:  w_rdata = r_cmp;
        SEL_TMR_CTRL: w_rdata = {29'b0, r_ctrl};
        SEL_TMR_STAT: w_rdata = {31'b0, r_match};
        default:      w_rdata = '0;
      endcase
    end else if (w_ram_hit) begin
      w_rdata = r_ram[w_ram_idx];
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      o_rvalid <= 1'b0;
      o_rdata  <= '0;
    end else begin
      o_rvalid <= memread;
      if (memread) o_rdata <= w_rdata;
    end
  end

  // RAM has no reset; contents are undefined until written.
  always_ff @(posedge clock) begin
    if (memwrite_cs && w_ram_hit) r_ram[w_ram_idx] <= i_wdata;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      o_gpio <= '0;
    end else if (w_wr_reg) begin
      case (w_sel)
        SEL_GPIO_OUT: o_gpio <= i_wdata[GPIO_W-1:0];
        SEL_GPIO_SET: o_gpio <= o_gpio | i_wdata[GPIO_W-1:0];
        SEL_GPIO_CLR: o_gpio <= o_gpio & ~i_wdata[GPIO_W-1:0];
        SEL_GPIO_TGL: o_gpio <= o_gpio ^ i_wdata[GPIO_W-1:0];
        default:      o_gpio <= o_gpio;
      endcase
    end
  end

  assign w_match_now = r_ctrl[0] && (r_cnt == r_cmp);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_cmp   <= 32'hFFFF_FFFF;
      r_ctrl  <= '0;
      r_match <= 1'b0;
    end else begin
      // A CPU write to the counter beats both increment and reload.
      if (w_wr_reg && w_sel == SEL_TMR_CNT) r_cnt <= i_wdata;
      else if (w_match_now && r_ctrl[1])    r_cnt <= '0;
      else if (r_ctrl[0])                   r_cnt <= r_cnt + 32'd1;

      if (w_wr_reg && w_sel == SEL_TMR_CMP)  r_cmp  <= i_wdata;
      if (w_wr_reg && w_sel == SEL_TMR_CTRL) r_ctrl <= i_wdata[2:0];

      // A new match wins over a same-cycle write-1-to-clear.
      if (w_match_now)                                   r_match <= 1'b1;
      else if (w_wr_reg && w_sel == SEL_TMR_STAT && i_wdata[0]) r_match <= 1'b0;
    end
  end

  // Both operands are flops, so there is no path from inputs to o_irq.
  assign o_irq = r_match & r_ctrl[2];

endmodule

// File: tb/tb_mmio_subsys.sv
module tb_mmio_subsys;

  logic        clock;
  logic        rst;
  logic        memread;
  logic        memwrite_cs;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_rvalid;
  logic [7:0]  o_gpio;
  logic        o_irq;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [31:0] exp_q[$];

  mmio_subsys #(.RAM_WORDS(16), .GPIO_W(8)) dut (
    .clock       (clock),
    .rst         (rst),
    .memread     (memread),
    .memwrite_cs (memwrite_cs),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_rdata     (o_rdata),
    .o_rvalid    (o_rvalid),
    .o_gpio      (o_gpio),
    .o_irq       (o_irq)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers (entered and left at a negedge) ----------------
  task automatic idle();
    @(negedge clock);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    memwrite_cs = 1'b1;
    i_addr      = a;
    i_wdata     = d;
    @(negedge clock);
    memwrite_cs = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    memread = 1'b1;
    i_addr  = a;
    exp_q.push_back(exp);
    @(negedge clock);
    memread = 1'b0;
    check_eq({tag, "_rvalid"}, {31'b0, o_rvalid}, 32'd1);
    check_eq(tag, o_rdata, exp_q.pop_front());
  endtask

  task automatic bus_rw(input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string tag);
    memread     = 1'b1;
    memwrite_cs = 1'b1;
    i_addr      = a;
    i_wdata     = d;
    exp_q.push_back(exp);
    @(negedge clock);
    memread     = 1'b0;
    memwrite_cs = 1'b0;
    check_eq({tag, "_rvalid"}, {31'b0, o_rvalid}, 32'd1);
    check_eq(tag, o_rdata, exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b0;
    memread     = 1'b0;
    memwrite_cs = 1'b0;
    i_addr      = '0;
    i_wdata     = '0;
    repeat (3) @(negedge clock);
    check_eq("rst_rdata",  o_rdata,          32'h0);
    check_eq("rst_rvalid", {31'b0, o_rvalid}, 32'h0);
    check_eq("rst_gpio",   {24'b0, o_gpio},  32'h0);
    check_eq("rst_irq",    {31'b0, o_irq},   32'h0);
    rst = 1'b1;
    idle();

    // RAM
    bus_write(32'h3C, 32'hDEADBEEF);
    bus_read (32'h3C, 32'hDEADBEEF, "ram_3c");
    bus_write(32'h00, 32'h12345678);
    bus_read (32'h00, 32'h12345678, "ram_00");
    idle();
    check_eq("hold_rvalid", {31'b0, o_rvalid}, 32'h0);
    check_eq("hold_rdata",  o_rdata,           32'h12345678);
    bus_read (32'h40, 32'h0, "unmapped_40");
    bus_write(32'h500, 32'h0000CAFE);
    bus_read (32'h500, 32'h0, "unmapped_500");
    bus_read (32'h3C, 32'hDEADBEEF, "ram_3c_again");

    // GPIO
    bus_write(32'h400, 32'hA5);
    check_eq("gpio_out", {24'b0, o_gpio}, 32'hA5);
    bus_write(32'h404, 32'h0A);
    check_eq("gpio_set", {24'b0, o_gpio}, 32'hAF);
    bus_write(32'h408, 32'h81);
    check_eq("gpio_clr", {24'b0, o_gpio}, 32'h2E);
    bus_write(32'h40C, 32'hFF);
    check_eq("gpio_tgl", {24'b0, o_gpio}, 32'hD1);
    bus_read (32'h400, 32'hD1, "gpio_rd");
    bus_read (32'h404, 32'h0, "gpio_set_rd");

    // same-cycle read and write
    bus_write(32'h400, 32'h11);
    bus_rw   (32'h400, 32'h22, 32'h11, "rw_old");
    check_eq("rw_gpio", {24'b0, o_gpio}, 32'h22);
    bus_read (32'h400, 32'h22, "rw_new");

    // timer: reset values, then compare=3 with reload and irq
    bus_read (32'h414, 32'hFFFFFFFF, "cmp_rst");
    bus_read (32'h418, 32'h0, "ctrl_rst");
    bus_write(32'h414, 32'd3);
    bus_write(32'h418, 32'h7);
    bus_read (32'h410, 32'd0, "cnt0");
    bus_read (32'h410, 32'd1, "cnt1");
    bus_read (32'h410, 32'd2, "cnt2");
    check_eq("irq_before", {31'b0, o_irq}, 32'd0);
    bus_read (32'h410, 32'd3, "cnt3");
    check_eq("irq_match", {31'b0, o_irq}, 32'd1);
    bus_read (32'h410, 32'd0, "cnt_reload");
    bus_write(32'h41C, 32'h1);
    check_eq("irq_cleared", {31'b0, o_irq}, 32'd0);
    idle();
    check_eq("irq_idle", {31'b0, o_irq}, 32'd0);
    bus_write(32'h41C, 32'h1);               // lands on the cnt==3 edge
    check_eq("irq_w1c_race", {31'b0, o_irq}, 32'd1);
    bus_read (32'h41C, 32'h1, "stat_race");

    // wrap, and counter write overriding the increment
    bus_write(32'h418, 32'h0);
    bus_write(32'h41C, 32'h1);
    bus_read (32'h41C, 32'h0, "stat_clr");
    bus_write(32'h410, 32'hFFFFFFFE);
    bus_write(32'h418, 32'h1);
    bus_read (32'h410, 32'hFFFFFFFE, "wrap0");
    bus_read (32'h410, 32'hFFFFFFFF, "wrap1");
    bus_read (32'h410, 32'h0, "wrap2");
    bus_write(32'h410, 32'd5);
    bus_read (32'h410, 32'd5, "cnt_override");
    bus_write(32'h418, 32'h0);

    // reset during a pending read
    bus_write(32'h400, 32'hFF);
    check_eq("gpio_ff", {24'b0, o_gpio}, 32'hFF);
    bus_write(32'h410, 32'd0);
    bus_write(32'h414, 32'd0);
    bus_write(32'h418, 32'h7);
    idle();
    check_eq("irq_pre_rst", {31'b0, o_irq}, 32'd1);
    memread = 1'b1;
    i_addr  = 32'h3C;
    @(posedge clock);
    #1;
    check_eq("pend_rvalid", {31'b0, o_rvalid}, 32'd1);
    rst     = 1'b0;
    memread = 1'b0;
    #1;
    check_eq("arst_rdata",  o_rdata,           32'h0);
    check_eq("arst_rvalid", {31'b0, o_rvalid}, 32'h0);
    check_eq("arst_gpio",   {24'b0, o_gpio},   32'h0);
    check_eq("arst_irq",    {31'b0, o_irq},    32'h0);
    repeat (2) @(negedge clock);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check_eq("post_rst_rvalid", {31'b0, o_rvalid}, 32'h0);
    end
    bus_read (32'h500, 32'h0, "post_rst_500");
    bus_read (32'h410, 32'h0, "post_rst_cnt");
    bus_read (32'h414, 32'hFFFFFFFF, "post_rst_cmp");
    bus_read (32'h418, 32'h0, "post_rst_ctrl");
    bus_read (32'h41C, 32'h0, "post_rst_stat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mmio_subsys.md
MMIO_SUBSYS -- requirements
Module: mmio_subsys

Interface
REQ-001 Parameter RAM_WORDS, default 16, sets the number of 32-bit RAM words (power of two, 4..1024).
REQ-002 Parameter GPIO_W, default 8, sets the GPIO output width (1..32).
REQ-003 Port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-low.
REQ-005 Port memread, input, 1: read strobe from the core, one request per cycle.
REQ-006 Port memwrite_cs, input, 1: write strobe from the core.
REQ-007 Port i_addr, input, 32: byte address; bits [1:0] are ignored.
REQ-008 Port i_wdata, input, 32: write data.
REQ-009 Port o_rdata, output, 32: read data.
REQ-010 Port o_rvalid, output, 1: one-cycle pulse qualifying o_rdata.
REQ-011 Port o_gpio, output, GPIO_W: GPIO output register.
REQ-012 Port o_irq, output, 1: timer interrupt, level.

Function
REQ-013 Address map SHALL be:
- RAM at 0x000..RAM_WORDS*4-1
- GPIO_OUT 0x400 (R/W)
- GPIO_SET 0x404 (W)
- GPIO_CLR 0x408 (W)
- GPIO_TGL 0x40C (W)
- TMR_CNT 0x410 (R/W)
- TMR_CMP 0x414 (R/W)
- TMR_CTRL 0x418 (R/W; bit0 enable, bit1 auto-reload, bit2 irq enable)
- TMR_STAT 0x41C (R; bit0 match; write-1-to-clear)
REQ-014 Reads SHALL have latency 1: address sampled on the edge where memread=1; o_rdata valid and o_rvalid=1 for exactly the following cycle.
REQ-015 o_rdata SHALL hold its last value while o_rvalid=0.
REQ-016 Back-to-back reads SHALL be supported at one per cycle.
REQ-017 Reads of unmapped addresses, or of write-only registers, SHALL return 0 with o_rvalid=1.
REQ-018 Writes to unmapped addresses SHALL be ignored.
REQ-019 Writes SHALL take effect on the edge where memwrite_cs=1.
REQ-020 When memread and memwrite_cs are both high to the same address, the read SHALL return the pre-write value.
REQ-021 GPIO_SET, GPIO_CLR and GPIO_TGL SHALL apply i_wdata[GPIO_W-1:0] as OR, AND-NOT and XOR masks on o_gpio, respectively.
REQ-022 Reads of GPIO_OUT SHALL return o_gpio zero-extended to 32 bits.
REQ-023 The timer, when enable=1, SHALL increment TMR_CNT by 1 each cycle, wrapping modulo 2^32.
REQ-024 When enable=1 and TMR_CNT==TMR_CMP, the next edge SHALL:
- set the match bit
- load TMR_CNT with 0 if auto-reload=1, otherwise continue incrementing.
REQ-025 A CPU write to TMR_CNT SHALL override the increment and reload in that cycle.
REQ-026 When a write-1-to-clear of match and a new match occur in the same cycle, match SHALL remain set.
REQ-027 o_irq SHALL equal match AND irq-enable, driven from registers with no combinational path from inputs.

Reset
REQ-028 While rst=0, the block SHALL hold: o_rdata=0, o_rvalid=0, o_gpio=0, o_irq=0, TMR_CNT=0, TMR_CMP=0xFFFFFFFF, TMR_CTRL=0, match=0.
REQ-029 A read pending when rst asserts SHALL be discarded; o_rvalid SHALL NOT pulse after rst releases.
REQ-030 RAM contents SHALL NOT be reset; values are undefined until written.

Verification
REQ-031 Write 0xDEADBEEF to 0x3C, then read 0x3C -> o_rvalid=1 one cycle after memread, o_rdata=0xDEADBEEF.
REQ-032 Write 0xA5 to GPIO_OUT, SET 0x0A, CLR 0x81, TGL 0xFF -> o_gpio=0xA5, then 0xAF, 0x2E, 0xD1.
REQ-033 TMR_CMP=3, TMR_CTRL=0x7 -> match and o_irq rise at the edge after TMR_CNT=3; TMR_CNT reads 0, 1, 2, 3, 0; write 1 to TMR_STAT clears o_irq.
REQ-034 Write 1 to TMR_STAT in the same cycle as a new match -> match stays 1.
REQ-035 Same-cycle read and write of 0x400 (old 0x11, new 0x22) -> read returns 0x11; a subsequent read returns 0x22.
REQ-036 Assert rst during a pending read with o_gpio=0xFF -> all outputs 0 immediately; no o_rvalid pulse after release; read of 0x500 -> 0.
